// File: rtl/pipe_control.sv
// pipe_control: ID/EX control decode, load-use stall FSM and flush, saturating event counters; stalling enabled by PIPE_CONTROL_HAZARD_EN
module pipe_control #(
  parameter int INSTR_W = 16,
  parameter int OP_W = 3,
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               flush,
  output logic               ex_reg_write,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_mem_write,
  output logic               ex_mem_read,
  output logic               ex_mem_to_reg,
  output logic [1:0]         ex_alu_op,
  output logic [REG_W-1:0]   ex_rt,
  output logic               stall,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);
  typedef enum logic {RUN, HOLD} state_t;
  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctl_t;
  state_t state_q, state_d;
  ctl_t dec, ctl_d, ctl_q;
  logic [OP_W-1:0] op;
  logic [REG_W-1:0] rt, dec_rt, ex_rt_d, ex_rt_q;
  logic live, is_r, is_beq, is_addi, is_lw, is_sw, known, hazard;
  logic [CNT_W-1:0] flush_count_d, flush_count_q;
  assign op = instr[INSTR_W-1 -: OP_W];
  assign rt = instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
  always_comb begin
    live = instr_valid && |instr;
    is_r = live && op == OP_W'(0);
    is_beq = live && op == OP_W'(2);
    is_addi = live && op == OP_W'(3);
    is_lw = live && op == OP_W'(5);
    is_sw = live && op == OP_W'(6);
    known = is_r | is_beq | is_addi | is_lw | is_sw;
    dec = '0;
    dec.reg_write = is_r | is_addi | is_lw;
    dec.reg_dst = is_r;
    dec.alu_src = is_addi | is_lw | is_sw;
    dec.branch = is_beq;
    dec.mem_write = is_sw;
    dec.mem_read = is_lw;
    dec.mem_to_reg = is_lw;
    dec.alu_op = is_r ? 2'd2 : is_beq ? 2'd1 : 2'd0;
    dec_rt = known ? rt : '0;
  end
`ifdef PIPE_CONTROL_HAZARD_EN
  logic [REG_W-1:0] rs;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;
  assign rs = instr[INSTR_W-OP_W-1 -: REG_W];
  assign hazard = ctl_q.mem_read && |ex_rt_q && instr_valid &&
                  ((known && rs == ex_rt_q) || ((is_r | is_beq | is_sw) && rt == ex_rt_q));
  assign stall_count_d = (stall && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
  always_ff @(posedge clock)
    stall_count_q <= reset ? '0 : stall_count_d;
  assign stall_count = stall_count_q;
`else
  assign hazard = 1'b0;
  assign stall_count = '0;
`endif
  // HOLD never stalls: the bubble just loaded into EX already resolves the hazard
  always_comb begin
    stall = !reset && !flush && state_q == RUN && hazard;
    state_d = stall ? HOLD : RUN;
    ctl_d = (flush || stall) ? '0 : dec;
    ex_rt_d = (flush || stall) ? '0 : dec_rt;
    flush_count_d = (flush && !(&flush_count_q)) ? flush_count_q + CNT_W'(1) : flush_count_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      ctl_q <= '0;
      ex_rt_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q <= ctl_d;
      ex_rt_q <= ex_rt_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign {ex_reg_write, ex_reg_dst, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_alu_op} = ctl_q;
  assign ex_rt = ex_rt_q;
  assign flush_count = flush_count_q;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed self-checking bench for pipe_control
module tb_pipe_control;
`ifdef PIPE_CONTROL_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  logic clock = 1'b0, reset, instr_valid, flush;
  logic [15:0] instr;
  logic rw, rd_, as, br, mw, mr, mtr;
  logic [1:0] aop;
  logic [2:0] ex_rt;
  logic stall;
  logic [15:0] sc, fc;
  logic b_rw, b_rd, b_as, b_br, b_mw, b_mr, b_mtr, b_stall;
  logic [1:0] b_aop;
  logic [2:0] b_rt;
  logic [1:0] b_sc, b_fc;
  logic [8:0] cw;
  int tests = 0, fails = 0, exp_sc = 0, exp_fc = 0;
  localparam logic [8:0] CW_R = 9'b1_1_0_0_0_0_0_10;
  localparam logic [8:0] CW_BEQ = 9'b0_0_0_1_0_0_0_01;
  localparam logic [8:0] CW_ADDI = 9'b1_0_1_0_0_0_0_00;
  localparam logic [8:0] CW_LW = 9'b1_0_1_0_0_1_1_00;
  localparam logic [8:0] CW_SW = 9'b0_0_1_0_1_0_0_00;
  always #5 clock = ~clock;
  assign cw = {rw, rd_, as, br, mw, mr, mtr, aop};
  pipe_control dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .ex_reg_write(rw), .ex_reg_dst(rd_), .ex_alu_src(as), .ex_branch(br), .ex_mem_write(mw),
    .ex_mem_read(mr), .ex_mem_to_reg(mtr), .ex_alu_op(aop), .ex_rt(ex_rt), .stall(stall),
    .stall_count(sc), .flush_count(fc)
  );
  pipe_control #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .ex_reg_write(b_rw), .ex_reg_dst(b_rd), .ex_alu_src(b_as), .ex_branch(b_br), .ex_mem_write(b_mw),
    .ex_mem_read(b_mr), .ex_mem_to_reg(b_mtr), .ex_alu_op(b_aop), .ex_rt(b_rt), .stall(b_stall),
    .stall_count(b_sc), .flush_count(b_fc)
  );
  function automatic logic [15:0] enc(input int op, input int rs, input int rt, input int rd);
    return {op[2:0], rs[2:0], rt[2:0], rd[2:0], 4'b0};
  endfunction
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] i, input logic f);
    instr_valid = v;
    instr = i;
    flush = f;
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, enc(0, 3, 4, 5), 1'b0);
    step();
    step();
    tests++;
    if (cw !== 9'd0 || ex_rt !== 3'd0) begin fails++; $display("FAIL reset_ctl: cw=%b rt=%0d want 0", cw, ex_rt); end
    tests++;
    if (sc !== 16'd0 || fc !== 16'd0 || stall !== 1'b0) begin fails++; $display("FAIL reset_cnt: sc=%0d fc=%0d stall=%b want 0", sc, fc, stall); end
    reset = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
  endtask
  task automatic test_zero_instr();
    drive(1'b1, 16'h0000, 1'b0);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL zero_stall: got %b want 0", stall); end
    step();
    tests++;
    if (cw !== 9'd0 || ex_rt !== 3'd0) begin fails++; $display("FAIL zero_ctl: cw=%b rt=%0d want 0", cw, ex_rt); end
  endtask
  task automatic test_decode();
    logic [15:0] ins [8] = '{enc(3, 1, 2, 0), enc(0, 1, 2, 3), enc(2, 4, 5, 0), enc(5, 1, 6, 0),
                            enc(6, 2, 7, 0), enc(1, 1, 2, 3), enc(4, 1, 2, 3), enc(7, 1, 2, 3)};
    logic [8:0] ecw [8] = '{CW_ADDI, CW_R, CW_BEQ, CW_LW, CW_SW, 9'd0, 9'd0, 9'd0};
    logic [2:0] ert [8] = '{3'd2, 3'd2, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ins[i], 1'b0);
      step();
      tests++;
      if (cw !== ecw[i] || ex_rt !== ert[i])
        begin fails++; $display("FAIL decode_%0d: cw=%b rt=%0d want cw=%b rt=%0d", i, cw, ex_rt, ecw[i], ert[i]); end
    end
    drive(1'b0, enc(3, 1, 2, 0), 1'b0);
    step();
    tests++;
    if (cw !== 9'd0 || ex_rt !== 3'd0) begin fails++; $display("FAIL invalid_bubble: cw=%b rt=%0d want 0", cw, ex_rt); end
  endtask
  task automatic test_load_use();
    drive(1'b1, enc(5, 1, 3, 0), 1'b0);
    step();
    drive(1'b1, enc(0, 3, 4, 5), 1'b0);
    tests++;
    if (stall !== HZ) begin fails++; $display("FAIL lu_stall: got %b want %b", stall, HZ); end
    step();
    if (HZ) exp_sc++;
    tests++;
    if (cw !== (HZ ? 9'd0 : CW_R) || ex_rt !== (HZ ? 3'd0 : 3'd4))
      begin fails++; $display("FAIL lu_ex1: cw=%b rt=%0d", cw, ex_rt); end
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL lu_hold_stall: got %b want 0", stall); end
    step();
    tests++;
    if (cw !== CW_R || ex_rt !== 3'd4) begin fails++; $display("FAIL lu_ex2: cw=%b rt=%0d want %b 4", cw, ex_rt, CW_R); end
    tests++;
    if (sc !== 16'(exp_sc)) begin fails++; $display("FAIL lu_count: got %0d want %0d", sc, exp_sc); end
  endtask
  task automatic test_rt_use();
    drive(1'b1, enc(5, 1, 3, 0), 1'b0);
    step();
    drive(1'b1, enc(6, 2, 3, 0), 1'b0);
    tests++;
    if (stall !== HZ) begin fails++; $display("FAIL sw_rt_stall: got %b want %b", stall, HZ); end
    step();
    if (HZ) exp_sc++;
    drive(1'b1, enc(5, 1, 3, 0), 1'b0);
    step();
    drive(1'b1, enc(3, 1, 3, 0), 1'b0);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL addi_rt_nostall: got %b want 0", stall); end
    step();
    tests++;
    if (cw !== CW_ADDI || sc !== 16'(exp_sc)) begin fails++; $display("FAIL addi_rt_ex: cw=%b sc=%0d want %b %0d", cw, sc, CW_ADDI, exp_sc); end
  endtask
  task automatic test_flush();
    drive(1'b1, enc(5, 1, 3, 0), 1'b0);
    step();
    drive(1'b1, enc(0, 3, 4, 5), 1'b1);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", stall); end
    step();
    exp_fc++;
    tests++;
    if (cw !== 9'd0 || ex_rt !== 3'd0) begin fails++; $display("FAIL flush_bubble: cw=%b rt=%0d want 0", cw, ex_rt); end
    tests++;
    if (fc !== 16'(exp_fc) || sc !== 16'(exp_sc)) begin fails++; $display("FAIL flush_count: fc=%0d sc=%0d want %0d %0d", fc, sc, exp_fc, exp_sc); end
    drive(1'b1, enc(0, 3, 4, 5), 1'b0);
    step();
    tests++;
    if (cw !== CW_R) begin fails++; $display("FAIL flush_after: cw=%b want %b", cw, CW_R); end
  endtask
  task automatic test_r0();
    drive(1'b1, enc(5, 1, 0, 0), 1'b0);
    step();
    drive(1'b1, enc(0, 0, 0, 1), 1'b0);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL r0_stall: got %b want 0", stall); end
    step();
    tests++;
    if (cw !== CW_R) begin fails++; $display("FAIL r0_ex: cw=%b want %b", cw, CW_R); end
  endtask
  task automatic test_reset_hold();
    drive(1'b1, enc(5, 1, 3, 0), 1'b0);
    step();
    reset = 1'b1;
    drive(1'b1, enc(0, 3, 4, 5), 1'b0);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    step();
    reset = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
    drive(1'b1, enc(5, 1, 3, 0), 1'b0);
    step();
    drive(1'b1, enc(0, 3, 4, 5), 1'b0);
    step();
    if (HZ) exp_sc++;
    reset = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_hold_stall: got %b want 0", stall); end
    step();
    reset = 1'b0;
    exp_sc = 0;
    tests++;
    if (cw !== 9'd0 || ex_rt !== 3'd0 || sc !== 16'd0 || fc !== 16'd0)
      begin fails++; $display("FAIL reset_hold_clear: cw=%b rt=%0d sc=%0d fc=%0d want 0", cw, ex_rt, sc, fc); end
    step();
    tests++;
    if (cw !== CW_R) begin fails++; $display("FAIL reset_hold_next: cw=%b want %b", cw, CW_R); end
  endtask
  task automatic test_saturate();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, enc(5, 1, 3, 0), 1'b0);
      step();
      drive(1'b1, enc(0, 3, 4, 5), 1'b0);
      tests++;
      if (b_stall !== HZ) begin fails++; $display("FAIL sat_stall_%0d: got %b want %b", i, b_stall, HZ); end
      step();
    end
    tests++;
    if (sc !== (HZ ? 16'd5 : 16'd0) || b_sc !== (HZ ? 2'd3 : 2'd0))
      begin fails++; $display("FAIL sat_stall_count: sc=%0d sc2=%0d want %0d %0d", sc, b_sc, HZ ? 5 : 0, HZ ? 3 : 0); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0000, 1'b1);
      step();
    end
    flush = 1'b0;
    tests++;
    if (fc !== 16'd5 || b_fc !== 2'd3) begin fails++; $display("FAIL sat_flush_count: fc=%0d fc2=%0d want 5 3", fc, b_fc); end
  endtask
  initial begin
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    flush = 1'b0;
    test_reset();
    test_zero_instr();
    test_decode();
    test_load_use();
    test_rt_use();
    test_flush();
    test_r0();
    test_reset_hold();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter INSTR_W, default 16: instruction width.
REQ-002 SHALL have parameter OP_W, default 3: opcode width, field instr[INSTR_W-1 -: OP_W].
REQ-003 SHALL have parameter REG_W, default 3: register specifier width; rs, rt, rd follow the opcode, MSB first.
REQ-004 SHALL have parameter CNT_W, default 16: stall/flush counter width.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port instr, input, INSTR_W: instruction from the IF/ID register.
REQ-008 SHALL have port instr_valid, input, 1: instr is a real instruction.
REQ-009 SHALL have port flush, input, 1: taken branch resolved; squash the decoding instruction.
REQ-010 SHALL have registered outputs ex_reg_write, ex_reg_dst, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_mem_to_reg, each 1 bit, plus ex_alu_op (2 bits): the ID/EX control word.
REQ-011 SHALL have port ex_rt, output, REG_W: registered rt of the instruction in EX.
REQ-012 SHALL have port stall, output, 1: combinational; hold PC and IF/ID this cycle.
REQ-013 SHALL have ports stall_count and flush_count, output, CNT_W each: saturating event counters.

Function
REQ-014 SHALL decode the opcode, zero-extended, as follows. 0 R-type: RegWrite=1, RegDst=1, ALUOp=2. 2 BEQ: Branch=1, ALUOp=1. 3 ADDI: RegWrite=1, ALUSrc=1, ALUOp=0. 5 LW: RegWrite=1, ALUSrc=1, MemRead=1, MemtoReg=1. 6 SW: ALUSrc=1, MemWrite=1. Every unlisted signal SHALL be 0.
REQ-015 SHALL decode any other opcode, an all-zero instr, or instr_valid=0 as a bubble (all control bits 0, ex_rt=0).
REQ-016 SHALL have one cycle of latency: the control word decoded in cycle N appears on the ex_* outputs in cycle N+1.
REQ-017 SHALL use source registers per opcode: R-type, BEQ and SW read rs and rt; ADDI and LW read rs only; bubbles read none.
REQ-018 SHALL raise the load-use hazard when ex_mem_read=1, ex_rt!=0, instr_valid=1, and ex_rt equals a source register of instr.
REQ-019 SHALL drive stall=1 during a hazard cycle while flush=0; on the next edge the ID/EX register SHALL load a bubble.
REQ-020 SHALL implement an FSM with states RUN and HOLD. RUN goes to HOLD on a hazard with flush=0; HOLD always returns to RUN after one cycle.
REQ-021 SHALL keep stall=0 in HOLD. Because a bubble is in EX, no back-to-back stall occurs for the same load.
REQ-022 SHALL give flush priority over stall: ID/EX loads a bubble, stall=0, and the FSM goes to RUN.
REQ-023 SHALL increment stall_count on each cycle with stall=1, and flush_count on each cycle with flush=1. Both counters SHALL saturate at all-ones and never wrap.
REQ-024 SHALL apply the priority reset > flush > stall > normal decode.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, clear all ex_* outputs and ex_rt to 0, set the FSM to RUN, and clear both counters to 0.
REQ-026 SHALL hold stall=0 whenever reset=1. A reset during HOLD SHALL discard the pending bubble.

Configuration
REQ-027 SHALL implement macro PIPE_CONTROL_HAZARD_EN. When defined: REQ-018 to REQ-021 and stall_count are active.
REQ-028 SHALL, when PIPE_CONTROL_HAZARD_EN is undefined, tie stall to 0 and stall_count to 0, keep the FSM permanently in RUN, and leave decode and flush behaviour unchanged.

Verification
REQ-029 SHALL cover: reset, then instr=16'h0000 with valid=1 -> all ex_* = 0 next cycle, stall=0.
REQ-030 SHALL cover: ADDI (op 3, rs=1, rt=2) -> next cycle ex_reg_write=1, ex_alu_src=1, ex_alu_op=0, ex_rt=2.
REQ-031 SHALL cover: LW with rt=3, then an R-type reading rs=3 -> stall=1 for exactly 1 cycle, a bubble in EX, R-type control one cycle later, stall_count=1.
REQ-032 SHALL cover: LW with rt=3, then an R-type reading rs=3, with flush=1 in the hazard cycle -> stall=0, bubble, flush_count=1.
REQ-033 SHALL cover: LW with rt=0, then an instruction reading r0 -> no stall.
REQ-034 SHALL cover: CNT_W=2 with 5 stalls -> stall_count=3; with the macro undefined, the same LW-use sequence -> stall stays 0.
